button_led_sequencer: RTL and testbench

- Sits between the board push-buttons (butons[1:0]) and the board LEDs (leds[3:0]) in the Lab2 top level.
- Synchronises and debounces both buttons, then produces single-cycle press pulses.
- Runs a 4-mode LED pattern state machine, with the pattern rate set by a tick prescaler.
- Button 0 advances the mode; button 1 pauses or resumes the pattern.

---
 rtl/button_led_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_button_led_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_led_sequencer.sv
// -----------------------------------------------------------------------------
// button_led_sequencer
//
// Sits between the two board push-buttons and the four board LEDs.
// Each button is level-normalised, synchronised, debounced and turned into a
// one-cycle press pulse. Button 0 steps a 4-mode LED pattern machine
// (STATIC -> COUNT -> SHIFT -> BLINK -> STATIC). Button 1 pauses or resumes
// the pattern. A prescaler sets the pattern step rate.
//
// Ports
//   io_systemClk    in   1  system clock, rising edge
//   io_asyncResetn  in   1  active-low reset, sampled synchronously
//   butons          in   2  raw button pins, asynchronous
//   leds            out  4  LED drive, 1 = lit, registered
//   mode            out  2  0 STATIC, 1 COUNT, 2 SHIFT, 3 BLINK
//   paused          out  1  1 = pattern stepping halted
//   btn_press       out  2  one-cycle pulse per accepted press
// -----------------------------------------------------------------------------

// Per-button conditioning: polarity fix, 2-flop synchroniser, debounce
// counter and rising-edge press pulse. Everything is in the "pressed = 1"
// domain after the polarity fix, so reset puts the synchroniser at 0.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             pin_act;
   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             level_d;

   assign pin_act = ACTIVE_LOW ? ~pin : pin;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync    <= {sync[0], pin_act};
         level_d <= level;
         // Pulse one cycle after the debounced level rises; release is silent.
         press   <= level & ~level_d;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // DEBOUNCE_CYCLES consecutive disagreeing samples: accept.
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

module button_led_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TICK_CYCLES     = 25000000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       io_systemClk,
   input  logic       io_asyncResetn,
   input  logic [1:0] butons,
   output logic [3:0] leds,
   output logic [1:0] mode,
   output logic       paused,
   output logic [1:0] btn_press
);

   localparam int NUM_BTN = 2;
   localparam int TICK_W  = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

   typedef enum logic [1:0] {
      M_STATIC = 2'd0,
      M_COUNT  = 2'd1,
      M_SHIFT  = 2'd2,
      M_BLINK  = 2'd3
   } mode_t;

   logic [NUM_BTN-1:0] db_level;
   logic [NUM_BTN-1:0] press;

   mode_t              state_q, state_d;
   logic [3:0]         pat_q, pat_d;
   logic [3:0]         led_src;
   logic [TICK_W-1:0]  presc;
   logic               paused_q;
   logic               tick;
   logic               mode_chg;

   // ---------------------------------------------------------------- buttons
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (BTN_ACTIVE_LOW)
      ) u_db (
         .clk   (io_systemClk),
         .rst_n (io_asyncResetn),
         .pin   (butons[i]),
         .level (db_level[i]),
         .press (press[i])
      );
   end

   assign btn_press = press;
   assign mode_chg  = press[0];

   // -------------------------------------------------------------- prescaler
   // Frozen while paused; restarted from 0 on every mode change so the first
   // step of a new mode is a full period after entry.
   assign tick = ~paused_q & (presc == TICK_LAST);

   always_ff @(posedge io_systemClk) begin
      if (!io_asyncResetn) begin
         presc <= '0;
      end else if (mode_chg) begin
         presc <= '0;
      end else if (!paused_q) begin
         presc <= tick ? '0 : presc + TICK_W'(1);
      end
   end

   // ------------------------------------------------------------------ pause
   // A mode change always clears pause, even if button 1 fired the same cycle.
   always_ff @(posedge io_systemClk) begin
      if (!io_asyncResetn) begin
         paused_q <= 1'b0;
      end else if (mode_chg) begin
         paused_q <= 1'b0;
      end else if (press[1]) begin
         paused_q <= ~paused_q;
      end
   end

   assign paused = paused_q;

   // --------------------------------------------------------------- mode FSM
   always_ff @(posedge io_systemClk) begin
      if (!io_asyncResetn) begin
         state_q <= M_STATIC;
         pat_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      if (mode_chg) begin
         // Mode change wins over a coincident tick: load the entry value.
         unique case (state_q)
            M_STATIC: state_d = M_COUNT;
            M_COUNT:  state_d = M_SHIFT;
            M_SHIFT:  state_d = M_BLINK;
            M_BLINK:  state_d = M_STATIC;
            default:  state_d = M_STATIC;
         endcase
         pat_d = (state_d == M_SHIFT) ? 4'b0001 : 4'b0000;
      end else if (tick) begin
         unique case (state_q)
            M_COUNT: pat_d = pat_q + 4'd1;
            M_SHIFT: pat_d = {pat_q[2:0], pat_q[3]};
            M_BLINK: pat_d = ~pat_q;
            default: pat_d = pat_q;
         endcase
      end
   end

   assign mode = state_q;

   // ------------------------------------------------------------ LED output
   assign led_src = (state_q == M_STATIC) ? {2'b00, db_level} : pat_q;

   always_ff @(posedge io_systemClk) begin
      if (!io_asyncResetn) begin
         leds <= '0;
      end else begin
         leds <= led_src;
      end
   end

endmodule

// File: tb/tb_button_led_sequencer.sv
module tb_button_led_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] butons;
   logic [3:0] leds;
   logic [1:0] mode;
   logic       paused;
   logic [1:0] btn_press;

   int checks = 0;
   int errors = 0;

   button_led_sequencer #(
      .DEBOUNCE_CYCLES (4),
      .TICK_CYCLES     (3),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .io_systemClk   (clk),
      .io_asyncResetn (rst_n),
      .butons         (butons),
      .leds           (leds),
      .mode           (mode),
      .paused         (paused),
      .btn_press      (btn_press)
   );

   always #5 clk = ~clk;

   // t: negedge index from table start; btn is driven after the compare.
   typedef struct {
      int         t;
      logic [1:0] btn;
      logic [3:0] leds;
      logic [1:0] mode;
      logic       paused;
      logic [1:0] press;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int t, input logic [1:0] btn, input logic [3:0] l,
                      input logic [1:0] m, input logic p, input logic [1:0] bp);
      vec_t v;
      v.t = t; v.btn = btn; v.leds = l; v.mode = m; v.paused = p; v.press = bp;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      int cur;
      int pulses;

      //      t    btn    leds     mode  p     press
      add(  0, 2'b10, 4'b0000, 2'd0, 1'b0, 2'b00);  // press button 0
      add(  6, 2'b10, 4'b0000, 2'd0, 1'b0, 2'b00);
      add(  7, 2'b10, 4'b0001, 2'd0, 1'b0, 2'b01);  // edge + 7
      add(  8, 2'b11, 4'b0001, 2'd1, 1'b0, 2'b00);
      add(  9, 2'b11, 4'b0000, 2'd1, 1'b0, 2'b00);  // COUNT entry
      add( 11, 2'b11, 4'b0000, 2'd1, 1'b0, 2'b00);
      add( 12, 2'b11, 4'b0001, 2'd1, 1'b0, 2'b00);
      add( 15, 2'b11, 4'b0010, 2'd1, 1'b0, 2'b00);
      add( 18, 2'b11, 4'b0011, 2'd1, 1'b0, 2'b00);
      add( 54, 2'b11, 4'b1111, 2'd1, 1'b0, 2'b00);
      add( 57, 2'b11, 4'b0000, 2'd1, 1'b0, 2'b00);  // wrap
      add( 60, 2'b11, 4'b0001, 2'd1, 1'b0, 2'b00);
      add( 61, 2'b10, 4'b0001, 2'd1, 1'b0, 2'b00);
      add( 68, 2'b10, 4'b0011, 2'd1, 1'b0, 2'b01);
      add( 69, 2'b01, 4'b0100, 2'd2, 1'b0, 2'b00);  // SHIFT; press button 1
      add( 70, 2'b01, 4'b0001, 2'd2, 1'b0, 2'b00);
      add( 72, 2'b01, 4'b0001, 2'd2, 1'b0, 2'b00);
      add( 73, 2'b01, 4'b0010, 2'd2, 1'b0, 2'b00);
      add( 76, 2'b01, 4'b0100, 2'd2, 1'b0, 2'b10);
      add( 77, 2'b11, 4'b0100, 2'd2, 1'b1, 2'b00);  // paused
      add( 85, 2'b11, 4'b0100, 2'd2, 1'b1, 2'b00);
      add( 95, 2'b11, 4'b0100, 2'd2, 1'b1, 2'b00);
      add(107, 2'b01, 4'b0100, 2'd2, 1'b1, 2'b00);  // resume press
      add(114, 2'b01, 4'b0100, 2'd2, 1'b1, 2'b10);
      add(115, 2'b11, 4'b0100, 2'd2, 1'b0, 2'b00);
      add(116, 2'b11, 4'b0100, 2'd2, 1'b0, 2'b00);
      add(117, 2'b11, 4'b1000, 2'd2, 1'b0, 2'b00);
      add(119, 2'b11, 4'b1000, 2'd2, 1'b0, 2'b00);
      add(120, 2'b11, 4'b0001, 2'd2, 1'b0, 2'b00);
      add(121, 2'b10, 4'b0001, 2'd2, 1'b0, 2'b00);
      add(128, 2'b10, 4'b0100, 2'd2, 1'b0, 2'b01);
      add(129, 2'b11, 4'b1000, 2'd3, 1'b0, 2'b00);  // BLINK
      add(130, 2'b11, 4'b0000, 2'd3, 1'b0, 2'b00);
      add(133, 2'b11, 4'b1111, 2'd3, 1'b0, 2'b00);
      add(136, 2'b11, 4'b0000, 2'd3, 1'b0, 2'b00);
      add(140, 2'b10, 4'b1111, 2'd3, 1'b0, 2'b00);
      add(147, 2'b10, 4'b1111, 2'd3, 1'b0, 2'b01);
      add(148, 2'b11, 4'b0000, 2'd0, 1'b0, 2'b00);  // wrap to STATIC
      add(149, 2'b11, 4'b0001, 2'd0, 1'b0, 2'b00);
      add(154, 2'b11, 4'b0001, 2'd0, 1'b0, 2'b00);
      add(155, 2'b11, 4'b0000, 2'd0, 1'b0, 2'b00);  // release, no pulse
      add(160, 2'b10, 4'b0000, 2'd0, 1'b0, 2'b00);
      add(167, 2'b10, 4'b0001, 2'd0, 1'b0, 2'b01);
      add(168, 2'b11, 4'b0001, 2'd1, 1'b0, 2'b00);
      add(169, 2'b01, 4'b0000, 2'd1, 1'b0, 2'b00);
      add(172, 2'b01, 4'b0001, 2'd1, 1'b0, 2'b00);
      add(176, 2'b01, 4'b0010, 2'd1, 1'b0, 2'b10);
      add(177, 2'b11, 4'b0010, 2'd1, 1'b1, 2'b00);
      add(178, 2'b11, 4'b0011, 2'd1, 1'b1, 2'b00);
      add(190, 2'b00, 4'b0011, 2'd1, 1'b1, 2'b00);  // both while paused
      add(197, 2'b00, 4'b0011, 2'd1, 1'b1, 2'b11);
      add(198, 2'b11, 4'b0011, 2'd2, 1'b0, 2'b00);
      add(199, 2'b11, 4'b0001, 2'd2, 1'b0, 2'b00);
      add(201, 2'b11, 4'b0001, 2'd2, 1'b0, 2'b00);
      add(202, 2'b11, 4'b0010, 2'd2, 1'b0, 2'b00);
      add(210, 2'b00, 4'b1000, 2'd2, 1'b0, 2'b00);  // both while running
      add(217, 2'b00, 4'b0100, 2'd2, 1'b0, 2'b11);
      add(218, 2'b10, 4'b0100, 2'd3, 1'b0, 2'b00);  // keep button 0 held
      add(219, 2'b10, 4'b0000, 2'd3, 1'b0, 2'b00);
      add(221, 2'b10, 4'b0000, 2'd3, 1'b0, 2'b00);
      add(222, 2'b10, 4'b1111, 2'd3, 1'b0, 2'b00);

      // Reset with buttons released, then 20 idle cycles.
      rst_n  = 1'b0;
      butons = 2'b11;
      repeat (2) @(negedge clk);
      chk("in_reset", {leds, mode, paused, btn_press}, 9'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d", i), {leds, mode, paused, btn_press}, 9'd0);
      end

      // 3-cycle glitch on button 1 must be rejected.
      butons = 2'b01;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 2) butons = 2'b11;
         chk($sformatf("glitch%0d", i), {leds, mode, paused, btn_press}, 9'd0);
      end

      // Table-driven main sequence.
      cur = 0;
      foreach (vecs[i]) begin
         while (cur < vecs[i].t) begin
            @(negedge clk);
            cur++;
         end
         chk($sformatf("t%0d leds", cur),   9'(leds),      9'(vecs[i].leds));
         chk($sformatf("t%0d mode", cur),   9'(mode),      9'(vecs[i].mode));
         chk($sformatf("t%0d paused", cur), 9'(paused),    9'(vecs[i].paused));
         chk($sformatf("t%0d press", cur),  9'(btn_press), 9'(vecs[i].press));
         butons = vecs[i].btn;
      end

      // Reset in BLINK at 1111 with button 0 held.
      @(negedge clk);
      chk("pre_rst leds", 9'(leds), 9'(4'b1111));
      chk("pre_rst mode", 9'(mode), 9'(2'd3));
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst", {leds, mode, paused, btn_press}, 9'd0);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (btn_press[0]) pulses++;
         chk($sformatf("post_rst+%0d press", k), 9'(btn_press),
             (k == 7) ? 9'd1 : 9'd0);
         if (k == 8) chk("post_rst mode", 9'(mode), 9'd1);
      end
      chk("post_rst pulses", 9'(pulses), 9'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
